// File: rtl/sandpile_frame_scheduler.sv
// Per-frame sequencer for the sandpile macro array: latches resolution, issues at most one drop,
// pulses new_frame and waits for completion. Optional macro SCHED_LFSR_EN selects LFSR auto-drops.
module sandpile_frame_scheduler #(
  parameter int MAX_SIZE = 32,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start_i,
  input  logic [8:0]       res_cfg_i,
  input  logic             user_req_i,
  input  logic [8:0]       user_x_i,
  input  logic [8:0]       user_y_i,
  output logic             user_ack_o,
  input  logic [7:0]       auto_period_i,
  output logic             new_frame_o,
  output logic             drop_o,
  output logic [8:0]       drop_x_o,
  output logic [8:0]       drop_y_o,
  output logic [8:0]       resolution_o,
  input  logic             array_done_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] overrun_cnt_o,
  output logic [CNT_W-1:0] timeout_cnt_o
);

  localparam logic [8:0] MAX_RES = 9'(MAX_SIZE);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SELECT, FRAME, WAIT_DONE} state_t;

  state_t           state, state_nxt;
  logic [8:0]       resolution_q;
  logic [7:0]       frame_cnt;
  logic             auto_pending;
  logic [8:0]       drop_x_q, drop_y_q;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] overrun_cnt, timeout_cnt;
  logic             timeout_hit;
  logic [8:0]       auto_x, auto_y;
  logic [8:0]       raw_x, raw_y, sel_x, sel_y;
  logic [7:0]       frame_cnt_inc;
  logic             auto_fire;

  function automatic logic [8:0] clamp_res(input logic [8:0] r);
    if (r < 9'd2)
      return 9'd2;
    else if (r > MAX_RES)
      return MAX_RES;
    return r;
  endfunction

  function automatic logic [8:0] clamp_coord(input logic [8:0] c, input logic [8:0] r);
    return (c >= r) ? (r - 9'd1) : c;
  endfunction

`ifdef SCHED_LFSR_EN
  localparam int LOG = $clog2(MAX_SIZE);

  logic [15:0] lfsr;
  logic [8:0]  lfsr_x, lfsr_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= 16'hACE1;
    else if (frame_start_i)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Raw LFSR fields may exceed the grid; fold once, the common clamp catches the rest.
  always_comb begin
    lfsr_x = 9'(lfsr[LOG-1:0]);
    lfsr_y = 9'(lfsr[2*LOG-1:LOG]);
    auto_x = (lfsr_x >= resolution_q) ? (lfsr_x - resolution_q) : lfsr_x;
    auto_y = (lfsr_y >= resolution_q) ? (lfsr_y - resolution_q) : lfsr_y;
  end
`else
  assign auto_x = resolution_q >> 1;
  assign auto_y = resolution_q >> 1;
`endif

  assign raw_x = user_req_i ? user_x_i : auto_x;
  assign raw_y = user_req_i ? user_y_i : auto_y;
  assign sel_x = clamp_coord(raw_x, resolution_q);
  assign sel_y = clamp_coord(raw_y, resolution_q);

  assign frame_cnt_inc = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
  assign auto_fire     = (auto_period_i != 8'd0) && (frame_cnt_inc >= auto_period_i);

  always_comb begin
    state_nxt   = state;
    new_frame_o = 1'b0;
    drop_o      = 1'b0;
    user_ack_o  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start_i)
          state_nxt = SELECT;
      end
      SELECT: begin
        drop_o     = user_req_i | auto_pending;
        user_ack_o = user_req_i;
        state_nxt  = FRAME;
      end
      FRAME: begin
        new_frame_o = 1'b1;
        state_nxt   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (array_done_i) begin
          state_nxt = IDLE;
        end else if (timer == TMR_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Frame bookkeeping: resolution latch, auto-drop cadence and the one-deep pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolution_q <= MAX_RES;
      frame_cnt    <= 8'd0;
      auto_pending <= 1'b0;
    end else if (state == IDLE && frame_start_i) begin
      resolution_q <= clamp_res(res_cfg_i);
      if (auto_fire) begin
        frame_cnt    <= 8'd0;
        auto_pending <= 1'b1;
      end else begin
        frame_cnt <= frame_cnt_inc;
      end
    end else if (state == SELECT && !user_req_i) begin
      auto_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_x_q <= 9'd0;
      drop_y_q <= 9'd0;
    end else if (drop_o) begin
      drop_x_q <= sel_x;
      drop_y_q <= sel_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer <= '0;
    else if (state == WAIT_DONE)
      timer <= timer + 1'b1;
    else
      timer <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (frame_start_i && state != IDLE && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + 1'b1;
      if (timeout_hit && timeout_cnt != '1)
        timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  assign drop_x_o      = drop_o ? sel_x : drop_x_q;
  assign drop_y_o      = drop_o ? sel_y : drop_y_q;
  assign resolution_o  = resolution_q;
  assign busy_o        = (state != IDLE);
  assign overrun_cnt_o = overrun_cnt;
  assign timeout_cnt_o = timeout_cnt;

endmodule

// File: tb/tb_sandpile_frame_scheduler.sv
// Directed bench for sandpile_frame_scheduler (default build, SCHED_LFSR_EN undefined):
// per-frame vector table plus sequences for ignored done, overrun, timeout and mid-frame reset.
module tb_sandpile_frame_scheduler;

  localparam int TIMEOUT = 4096;
  localparam int NVEC    = 18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start_i = 1'b0;
  logic [8:0] res_cfg_i = 9'd0;
  logic       user_req_i = 1'b0;
  logic [8:0] user_x_i = 9'd0;
  logic [8:0] user_y_i = 9'd0;
  logic       user_ack_o;
  logic [7:0] auto_period_i = 8'd0;
  logic       new_frame_o;
  logic       drop_o;
  logic [8:0] drop_x_o, drop_y_o;
  logic [8:0] resolution_o;
  logic       array_done_i = 1'b0;
  logic       busy_o;
  logic [7:0] overrun_cnt_o, timeout_cnt_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] res_cfg;
    logic [7:0] period;
    logic       req;
    logic [8:0] ux;
    logic [8:0] uy;
    logic [8:0] exp_res;
    logic       exp_drop;
    logic       exp_ack;
    logic [8:0] exp_x;
    logic [8:0] exp_y;
  } vec_t;

  vec_t vecs [NVEC];

  sandpile_frame_scheduler #(.MAX_SIZE(32), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start_i), .res_cfg_i(res_cfg_i),
    .user_req_i(user_req_i), .user_x_i(user_x_i), .user_y_i(user_y_i), .user_ack_o(user_ack_o),
    .auto_period_i(auto_period_i), .new_frame_o(new_frame_o), .drop_o(drop_o),
    .drop_x_o(drop_x_o), .drop_y_o(drop_y_o), .resolution_o(resolution_o),
    .array_done_i(array_done_i), .busy_o(busy_o),
    .overrun_cnt_o(overrun_cnt_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One complete frame: start pulse, check select and frame cycles, then complete it.
  task automatic apply_stimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    res_cfg_i = v.res_cfg; auto_period_i = v.period;
    user_req_i = v.req; user_x_i = v.ux; user_y_i = v.uy;
    frame_start_i = 1'b1;
    @(negedge clk);
    check_output({tag, ".c0_drop"}, 32'(drop_o), 32'(0));
    @(posedge clk); #1;
    frame_start_i = 1'b0;
    @(negedge clk);
    check_output({tag, ".res"},     32'(resolution_o), 32'(v.exp_res));
    check_output({tag, ".drop"},    32'(drop_o),       32'(v.exp_drop));
    check_output({tag, ".ack"},     32'(user_ack_o),   32'(v.exp_ack));
    check_output({tag, ".x"},       32'(drop_x_o),     32'(v.exp_x));
    check_output({tag, ".y"},       32'(drop_y_o),     32'(v.exp_y));
    check_output({tag, ".c1_nf"},   32'(new_frame_o),  32'(0));
    @(posedge clk); #1;
    user_req_i = 1'b0;
    @(negedge clk);
    check_output({tag, ".c2_nf"},   32'(new_frame_o),  32'(1));
    check_output({tag, ".c2_drop"}, 32'(drop_o),       32'(0));
    check_output({tag, ".c2_x"},    32'(drop_x_o),     32'(v.exp_x));
    @(posedge clk); #1;
    array_done_i = 1'b1;
    @(posedge clk); #1;
    array_done_i = 1'b0;
    @(negedge clk);
    check_output({tag, ".idle"},    32'(busy_o),       32'(0));
  endtask

  initial begin
    int n;
    int pulses;

    vecs[0]  = '{9'd20,  8'd0, 1'b0, 9'd0,  9'd0,  9'd20, 1'b0, 1'b0, 9'd0,  9'd0};
    vecs[1]  = '{9'd32,  8'd0, 1'b1, 9'd5,  9'd7,  9'd32, 1'b1, 1'b1, 9'd5,  9'd7};
    vecs[2]  = '{9'd1,   8'd0, 1'b0, 9'd0,  9'd0,  9'd2,  1'b0, 1'b0, 9'd5,  9'd7};
    vecs[3]  = '{9'd500, 8'd0, 1'b1, 9'd40, 9'd3,  9'd32, 1'b1, 1'b1, 9'd31, 9'd3};
    vecs[4]  = '{9'd10,  8'd0, 1'b1, 9'd9,  9'd12, 9'd10, 1'b1, 1'b1, 9'd9,  9'd9};
    vecs[5]  = '{9'd32,  8'd3, 1'b0, 9'd0,  9'd0,  9'd32, 1'b1, 1'b0, 9'd16, 9'd16};
    vecs[6]  = '{9'd32,  8'd3, 1'b0, 9'd0,  9'd0,  9'd32, 1'b0, 1'b0, 9'd16, 9'd16};
    vecs[7]  = '{9'd32,  8'd3, 1'b0, 9'd0,  9'd0,  9'd32, 1'b0, 1'b0, 9'd16, 9'd16};
    vecs[8]  = '{9'd32,  8'd3, 1'b0, 9'd0,  9'd0,  9'd32, 1'b1, 1'b0, 9'd16, 9'd16};
    vecs[9]  = '{9'd32,  8'd3, 1'b0, 9'd0,  9'd0,  9'd32, 1'b0, 1'b0, 9'd16, 9'd16};
    vecs[10] = '{9'd32,  8'd3, 1'b0, 9'd0,  9'd0,  9'd32, 1'b0, 1'b0, 9'd16, 9'd16};
    vecs[11] = '{9'd32,  8'd3, 1'b1, 9'd4,  9'd6,  9'd32, 1'b1, 1'b1, 9'd4,  9'd6};
    vecs[12] = '{9'd32,  8'd3, 1'b0, 9'd0,  9'd0,  9'd32, 1'b1, 1'b0, 9'd16, 9'd16};
    vecs[13] = '{9'd32,  8'd3, 1'b0, 9'd0,  9'd0,  9'd32, 1'b0, 1'b0, 9'd16, 9'd16};
    vecs[14] = '{9'd24,  8'd3, 1'b0, 9'd0,  9'd0,  9'd24, 1'b1, 1'b0, 9'd12, 9'd12};
    vecs[15] = '{9'd0,   8'd0, 1'b0, 9'd0,  9'd0,  9'd2,  1'b0, 1'b0, 9'd12, 9'd12};
    vecs[16] = '{9'd0,   8'd0, 1'b1, 9'd1,  9'd5,  9'd2,  1'b1, 1'b1, 9'd1,  9'd1};
    vecs[17] = '{9'd33,  8'd0, 1'b1, 9'd31, 9'd32, 9'd32, 1'b1, 1'b1, 9'd31, 9'd31};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("rst.busy",    32'(busy_o),        32'(0));
    check_output("rst.drop",    32'(drop_o),        32'(0));
    check_output("rst.ack",     32'(user_ack_o),    32'(0));
    check_output("rst.nf",      32'(new_frame_o),   32'(0));
    check_output("rst.x",       32'(drop_x_o),      32'(0));
    check_output("rst.y",       32'(drop_y_o),      32'(0));
    check_output("rst.res",     32'(resolution_o),  32'(32));
    check_output("rst.overrun", 32'(overrun_cnt_o), 32'(0));
    check_output("rst.timeout", 32'(timeout_cnt_o), 32'(0));

    for (int i = 0; i < NVEC; i++)
      apply_stimulus(i, vecs[i]);

    $display("[TB] array_done outside WAIT_DONE");
    auto_period_i = 8'd0;
    @(posedge clk); #1;
    array_done_i = 1'b1;
    @(posedge clk); #1;
    frame_start_i = 1'b1;
    @(posedge clk); #1;
    frame_start_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    array_done_i = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy_o) n++;
    end
    check_output("ignore_done.busy", 32'(n), 32'(5));
    @(posedge clk); #1 array_done_i = 1'b1;
    @(posedge clk); #1 array_done_i = 1'b0;
    @(negedge clk);
    check_output("ignore_done.idle", 32'(busy_o), 32'(0));

    $display("[TB] overrun");
    @(posedge clk); #1 frame_start_i = 1'b1;
    @(posedge clk); #1 frame_start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 frame_start_i = 1'b1;
    @(posedge clk); #1 frame_start_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (drop_o || new_frame_o) pulses++;
    end
    check_output("overrun.one",       32'(overrun_cnt_o), 32'(1));
    check_output("overrun.no_pulses", 32'(pulses),        32'(0));
    check_output("overrun.busy",      32'(busy_o),        32'(1));
    @(posedge clk); #1 frame_start_i = 1'b1;
    repeat (300) @(posedge clk);
    #1 frame_start_i = 1'b0;
    @(negedge clk);
    check_output("overrun.sat",     32'(overrun_cnt_o), 32'(255));
    check_output("overrun.no_tmo",  32'(timeout_cnt_o), 32'(0));
    @(posedge clk); #1 array_done_i = 1'b1;
    @(posedge clk); #1 array_done_i = 1'b0;
    @(negedge clk);
    check_output("overrun.idle", 32'(busy_o), 32'(0));

    $display("[TB] timeout");
    @(posedge clk); #1 frame_start_i = 1'b1;
    @(posedge clk); #1 frame_start_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    n = 0;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      @(negedge clk);
      if (!busy_o) break;
      n++;
    end
    check_output("timeout.cycles", 32'(n),             32'(TIMEOUT));
    check_output("timeout.cnt",    32'(timeout_cnt_o), 32'(1));

    $display("[TB] reset mid-frame");
    @(posedge clk); #1;
    res_cfg_i = 9'd20; user_req_i = 1'b1; user_x_i = 9'd3; user_y_i = 9'd4;
    frame_start_i = 1'b1;
    @(posedge clk); #1;
    frame_start_i = 1'b0;
    check_output("midrst.drop_before", 32'(drop_o), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check_output("midrst.drop",    32'(drop_o),        32'(0));
    check_output("midrst.ack",     32'(user_ack_o),    32'(0));
    check_output("midrst.busy",    32'(busy_o),        32'(0));
    check_output("midrst.res",     32'(resolution_o),  32'(32));
    check_output("midrst.overrun", 32'(overrun_cnt_o), 32'(0));
    check_output("midrst.timeout", 32'(timeout_cnt_o), 32'(0));
    user_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (drop_o || new_frame_o || busy_o) pulses++;
    end
    check_output("midrst.quiet", 32'(pulses), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
